// File: rtl/pipe_pkg.sv
// pipe_pkg -- definitions shared by the pipeline memory-access stage.
//   state_t      : encoding of the memory-access FSM (IDLE, ACCESS, DONE)
//   REG_ADDR_W   : width of the destination register address (5 bits)
//   TIMEOUT_DATA : read data returned when the watchdog abandons a load
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int          REG_ADDR_W   = 5;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if -- request/acknowledge bus between the memory-access
// stage (master) and the data memory (slave).
//   mem_req   : master -> slave, an access is outstanding
//   mem_we    : master -> slave, 1 = write, 0 = read
//   mem_addr  : master -> slave, word-aligned address
//   mem_wdata : master -> slave, store data
//   mem_ack   : slave -> master, access completes in this cycle
//   mem_rdata : slave -> master, load data, valid with mem_ack
//
// Handshake: once mem_req rises, mem_req/mem_we/mem_addr/mem_wdata stay
// stable until the master samples mem_ack high on a rising clk edge; the
// transfer completes on that edge and mem_req drops after it. mem_ack while
// mem_req is low has no effect.
interface mem_access_stage_if #(
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_watchdog.sv
// mem_watchdog -- counts consecutive ACCESS cycles that ended without an
// acknowledge and flags the cycle in which the limit is reached.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : an ACCESS cycle without mem_ack
//   clear      : stage is outside ACCESS; restart the count
//   expired    : this enabled cycle is the TIMEOUT_CYCLES-th in a row
module mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q;

    // Combinational so the FSM can leave ACCESS on the same edge that
    // would otherwise have counted the limit-th cycle.
    assign expired = enable && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage -- pipeline MEM stage with a multi-cycle memory handshake.
// Optional feature macro: MEM_TIMEOUT_EN (ACCESS watchdog + sticky mem_error).
//   clk, rst_n          : clock, asynchronous active-low reset
//   MemRead..writedata  : control/data from EX/MEM
//   *Out, aluresultout,
//   memdataout          : control/data to MEM/WB
//   stall               : freezes PC, IF/ID, ID/EX, EX/MEM while high
//   mem                 : memory request/acknowledge bus (master side)
//   mem_error           : sticky watchdog flag (0 when the watchdog is absent)
//   state_dbg           : current FSM state
module mem_access_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  MemtoReg,
    input  logic                  RegWrite,
    input  logic [REG_ADDR_W-1:0] Write_address,
    input  logic [DATA_W-1:0]     aluresult,
    input  logic [DATA_W-1:0]     writedata,
    output logic                  MemtoRegOut,
    output logic                  RegWriteOut,
    output logic [REG_ADDR_W-1:0] Write_addressOut,
    output logic [DATA_W-1:0]     aluresultout,
    output logic [DATA_W-1:0]     memdataout,
    output logic                  stall,
    mem_access_stage_if.master    mem,
    output logic                  mem_error,
    output state_t                state_dbg
);
    state_t            state_q, state_d;
    logic              mem_op;
    logic              expired;
    logic              req_q, we_q;
    logic [DATA_W-1:0] addr_q, wdata_q, memdata_q;

    assign mem_op = MemRead | MemWrite;

`ifdef MEM_TIMEOUT_EN
    logic error_q;

    mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  ((state_q == ACCESS) && !mem.mem_ack),
        .clear   (state_q != ACCESS),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else if (expired) begin
            error_q <= 1'b1;
        end
    end

    assign mem_error = error_q;
`else
    assign expired   = 1'b0;
    assign mem_error = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (mem.mem_ack || expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The instruction leaves for MEM/WB at the end of this cycle;
                // its MemRead/MemWrite are already served.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            memdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && mem_op) begin
                req_q   <= 1'b1;
                we_q    <= MemWrite;    // read+write together is a write
                addr_q  <= {aluresult[DATA_W-1:2], 2'b00};
                wdata_q <= writedata;
            end else if (state_q == ACCESS) begin
                if (mem.mem_ack) begin
                    req_q <= 1'b0;
                    if (!we_q) begin
                        memdata_q <= mem.mem_rdata;
                    end
                end else if (expired) begin
                    req_q <= 1'b0;
                    if (!we_q) begin
                        memdata_q <= DATA_W'(TIMEOUT_DATA);
                    end
                end
            end
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    // Bubble into MEM/WB while stalled.
    assign MemtoRegOut      = MemtoReg & ~stall;
    assign RegWriteOut      = RegWrite & ~stall;
    assign Write_addressOut = Write_address;
    assign aluresultout     = aluresult;
    assign memdataout       = memdata_q;
    assign state_dbg        = state_q;
endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import pipe_pkg::*;

  localparam int DATA_W = 32;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic MemRead, MemWrite, MemtoReg, RegWrite;
  logic [4:0] Write_address, Write_addressOut;
  logic [DATA_W-1:0] aluresult, writedata, aluresultout, memdataout;
  logic MemtoRegOut, RegWriteOut, stall, mem_error;
  state_t state_dbg;

  mem_access_stage_if #(.DATA_W(DATA_W)) mem_bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .Write_address(Write_address), .aluresult(aluresult), .writedata(writedata),
    .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut),
    .Write_addressOut(Write_addressOut), .aluresultout(aluresultout),
    .memdataout(memdataout), .stall(stall), .mem(mem_bus.master),
    .mem_error(mem_error), .state_dbg(state_dbg)
  );

  int total = 0;
  int bad = 0;

  // driver tasks
  task automatic set_inputs(input logic rd, input logic wr, input logic m2r, input logic rw,
                            input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] wd);
    MemRead = rd; MemWrite = wr; MemtoReg = m2r; RegWrite = rw;
    Write_address = wa; aluresult = alu; writedata = wd;
  endtask

  task automatic set_nop();
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    set_nop();
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;
    rst_n = 1'b0;
    @(negedge clk); #1;
    total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
    total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mem_bus.mem_req); end
    total++; if (mem_bus.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_bus.mem_addr); end
    total++; if (memdataout !== 32'h0) begin bad++; $display("FAIL reset_memdata got=%h exp=0", memdataout); end
    total++; if (mem_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", mem_error); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    rst_n = 1'b1;
  endtask

  task automatic test_alu_op();
    @(negedge clk);
    set_inputs(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0042, 32'h0);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b exp=0", stall); end
    total++; if (aluresultout !== 32'h42) begin bad++; $display("FAIL alu_result got=%h exp=42", aluresultout); end
    total++; if (RegWriteOut !== 1'b1) begin bad++; $display("FAIL alu_regwrite got=%b exp=1", RegWriteOut); end
    total++; if (Write_addressOut !== 5'd7) begin bad++; $display("FAIL alu_waddr got=%0d exp=7", Write_addressOut); end
    set_inputs(1'b0, 1'b0, 1'b1, 1'b0, 5'd31, 32'hFFFF_0001, 32'h0);
    #1;
    total++; if (aluresultout !== 32'hFFFF_0001) begin bad++; $display("FAIL alu2_result got=%h exp=ffff0001", aluresultout); end
    total++; if (MemtoRegOut !== 1'b1 || RegWriteOut !== 1'b0) begin bad++; $display("FAIL alu2_ctrl got=%b%b exp=10", MemtoRegOut, RegWriteOut); end
  endtask

  task automatic test_load();
    int stalls;
    stalls = 0;
    @(negedge clk);
    set_inputs(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0103, 32'h0);
    #1;
    if (stall) stalls++;
    total++; if (RegWriteOut !== 1'b0 || MemtoRegOut !== 1'b0) begin bad++; $display("FAIL load_bubble got=%b%b exp=00", RegWriteOut, MemtoRegOut); end
    @(negedge clk);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hCAFEF00D;
    #1;
    if (stall) stalls++;
    total++; if (state_dbg !== ACCESS) begin bad++; $display("FAIL load_access got=%0d exp=%0d", state_dbg, ACCESS); end
    total++; if (mem_bus.mem_req !== 1'b1) begin bad++; $display("FAIL load_req got=%b exp=1", mem_bus.mem_req); end
    total++; if (mem_bus.mem_addr !== 32'h100) begin bad++; $display("FAIL load_addr got=%h exp=100", mem_bus.mem_addr); end
    total++; if (mem_bus.mem_we !== 1'b0) begin bad++; $display("FAIL load_we got=%b exp=0", mem_bus.mem_we); end
    @(negedge clk);
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
    #1;
    total++; if (state_dbg !== DONE) begin bad++; $display("FAIL load_done got=%0d exp=%0d", state_dbg, DONE); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL load_done_stall got=%b exp=0", stall); end
    total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL load_req_drop got=%b exp=0", mem_bus.mem_req); end
    total++; if (memdataout !== 32'hCAFEF00D) begin bad++; $display("FAIL load_data got=%h exp=cafef00d", memdataout); end
    total++; if (RegWriteOut !== 1'b1 || MemtoRegOut !== 1'b1) begin bad++; $display("FAIL load_wb got=%b%b exp=11", RegWriteOut, MemtoRegOut); end
    total++; if (stalls !== 2) begin bad++; $display("FAIL load_stalls got=%0d exp=2", stalls); end
    @(negedge clk);
    set_nop();
    #1;
    total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL load_back_idle got=%0d exp=%0d", state_dbg, IDLE); end
  endtask

  task automatic test_store_delayed();
    int stalls;
    stalls = 0;
    @(negedge clk);
    set_inputs(1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0200, 32'h1234_5678);
    #1;
    if (stall) stalls++;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      mem_bus.mem_ack = (k == 5);
      #1;
      if (stall) stalls++;
      total++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b1) begin bad++; $display("FAIL store_req_we c%0d got=%b%b exp=11", k, mem_bus.mem_req, mem_bus.mem_we); end
      total++; if (mem_bus.mem_addr !== 32'h200 || mem_bus.mem_wdata !== 32'h1234_5678) begin bad++; $display("FAIL store_hold c%0d got=%h/%h exp=200/12345678", k, mem_bus.mem_addr, mem_bus.mem_wdata); end
      total++; if (RegWriteOut !== 1'b0) begin bad++; $display("FAIL store_bubble c%0d got=%b exp=0", k, RegWriteOut); end
    end
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    #1;
    total++; if (state_dbg !== DONE || stall !== 1'b0) begin bad++; $display("FAIL store_done got=%0d/%b exp=%0d/0", state_dbg, stall, DONE); end
    total++; if (memdataout !== 32'hCAFEF00D) begin bad++; $display("FAIL store_memdata got=%h exp=cafef00d", memdataout); end
    total++; if (RegWriteOut !== 1'b1) begin bad++; $display("FAIL store_wb got=%b exp=1", RegWriteOut); end
    total++; if (stalls !== 6) begin bad++; $display("FAIL store_stalls got=%0d exp=6", stalls); end
    @(negedge clk);
    set_nop();
  endtask

  task automatic test_read_write_both();
    @(negedge clk);
    set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_01FF, 32'hA5A5_A5A5);
    @(negedge clk);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1111_1111;
    #1;
    total++; if (mem_bus.mem_we !== 1'b1) begin bad++; $display("FAIL both_we got=%b exp=1", mem_bus.mem_we); end
    total++; if (mem_bus.mem_addr !== 32'h1FC) begin bad++; $display("FAIL both_addr got=%h exp=1fc", mem_bus.mem_addr); end
    total++; if (mem_bus.mem_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL both_wdata got=%h exp=a5a5a5a5", mem_bus.mem_wdata); end
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    #1;
    total++; if (memdataout !== 32'hCAFEF00D) begin bad++; $display("FAIL both_memdata got=%h exp=cafef00d", memdataout); end
    @(negedge clk);
    set_nop();
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    set_inputs(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0300, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    total++; if (state_dbg !== ACCESS || mem_bus.mem_req !== 1'b1) begin bad++; $display("FAIL rst3_pre got=%0d/%b exp=%0d/1", state_dbg, mem_bus.mem_req, ACCESS); end
    rst_n = 1'b0;
    #1;
    total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst3_req got=%b exp=0", mem_bus.mem_req); end
    total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL rst3_state got=%0d exp=%0d", state_dbg, IDLE); end
    total++; if (memdataout !== 32'h0 || mem_bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rst3_regs got=%h/%h exp=0/0", memdataout, mem_bus.mem_addr); end
    set_nop();
    #1;
    rst_n = 1'b1;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h5555_AAAA;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      total++; if (state_dbg !== IDLE || mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL late_ack c%0d got=%0d/%b exp=%0d/0", k, state_dbg, mem_bus.mem_req, IDLE); end
      total++; if (memdataout !== 32'h0) begin bad++; $display("FAIL late_ack_data c%0d got=%h exp=0", k, memdataout); end
    end
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
  endtask

  task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    set_inputs(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h0000_0400, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      total++; if (state_dbg !== ACCESS || stall !== 1'b1) begin bad++; $display("FAIL to_access c%0d got=%0d/%b exp=%0d/1", k, state_dbg, stall, ACCESS); end
    end
    @(negedge clk); #1;
    total++; if (state_dbg !== DONE) begin bad++; $display("FAIL to_done got=%0d exp=%0d", state_dbg, DONE); end
    total++; if (memdataout !== 32'hDEADBEEF) begin bad++; $display("FAIL to_data got=%h exp=deadbeef", memdataout); end
    total++; if (mem_error !== 1'b1 || mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL to_error got=%b/%b exp=1/0", mem_error, mem_bus.mem_req); end
    @(negedge clk);
    set_nop();
    repeat (2) @(negedge clk);
    #1;
    total++; if (mem_error !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", mem_error); end
    rst_n = 1'b0;
    #1;
    total++; if (mem_error !== 1'b0) begin bad++; $display("FAIL to_clear got=%b exp=0", mem_error); end
    rst_n = 1'b1;
`else
    @(negedge clk);
    set_inputs(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h0000_0400, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      total++; if (state_dbg !== ACCESS || stall !== 1'b1 || mem_error !== 1'b0) begin bad++; $display("FAIL wait_access c%0d got=%0d/%b/%b exp=%0d/1/0", k, state_dbg, stall, mem_error, ACCESS); end
    end
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    #1;
    total++; if (state_dbg !== DONE || memdataout !== 32'h0BAD_F00D) begin bad++; $display("FAIL wait_done got=%0d/%h exp=%0d/0badf00d", state_dbg, memdataout, DONE); end
    @(negedge clk);
    set_nop();
`endif
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store_delayed();
    test_read_write_both();
    test_reset_mid_access();
    test_timeout();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 16, meaning the number of ACCESS cycles without mem_ack before the watchdog fires.
REQ-002 SHALL provide parameter DATA_W, default 32, meaning the data and address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have inputs from EX/MEM, each 1 bit: MemRead, MemWrite, MemtoReg, RegWrite.
REQ-006 SHALL have further inputs from EX/MEM: Write_address (5 bits), aluresult (DATA_W bits, effective address or ALU value) and writedata (DATA_W bits, store data).
REQ-007 SHALL have outputs to MEM/WB: MemtoRegOut (1), RegWriteOut (1), Write_addressOut (5), aluresultout (DATA_W), memdataout (DATA_W).
REQ-008 SHALL have output stall, 1 bit, to the hazard unit: when high, it freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-009 SHALL have memory-side outputs mem_req (1), mem_we (1), mem_addr (DATA_W) and mem_wdata (DATA_W).
REQ-010 SHALL have memory-side inputs mem_ack (1) and mem_rdata (DATA_W).
REQ-011 SHALL have output mem_error, 1 bit: sticky watchdog flag.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-013 In IDLE with MemRead|MemWrite low: stall=0; outputs pass through combinationally with zero latency; memdataout holds its last value.
REQ-014 In IDLE with MemRead|MemWrite high: stall=1 in that same cycle; next edge enters ACCESS, registers mem_req=1, and latches mem_addr={aluresult[31:2],2'b00}, mem_wdata=writedata and mem_we=MemWrite.
REQ-015 In ACCESS: stall=1; mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ack is sampled high.
REQ-016 On mem_ack high in ACCESS: mem_req drops at the next edge, the FSM enters DONE, and memdataout<=mem_rdata if mem_we=0 (otherwise unchanged).
REQ-017 In DONE: stall=0 and outputs pass through, so the instruction advances into MEM/WB at the end of DONE; next state is IDLE unconditionally, and MemRead/MemWrite are not re-evaluated in DONE.
REQ-018 Minimum memory-instruction latency SHALL be 2 stall cycles (IDLE plus one ACCESS cycle with ack).
REQ-019 RegWriteOut SHALL be forced to 0 and MemtoRegOut to 0 whenever stall=1, inserting a bubble into MEM/WB.
REQ-020 MemRead and MemWrite both high SHALL be treated as a write.
REQ-021 mem_ack sampled outside ACCESS SHALL be ignored.
REQ-022 aluresult[1:0] SHALL be ignored for addressing: word accesses only.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, memdataout=0, mem_error=0 and the watchdog count=0, including mid-ACCESS; the aborted access is not retried.

Configuration
REQ-024 With macro MEM_TIMEOUT_EN defined, a counter SHALL increment each ACCESS cycle without ack; on reaching TIMEOUT_CYCLES it forces DONE, memdataout<=32'hDEADBEEF for reads, and sets mem_error=1 until reset.
REQ-025 Without MEM_TIMEOUT_EN, ACCESS SHALL wait indefinitely and mem_error SHALL be tied to 0.

Structure
REQ-026 Shared package pipe_pkg SHALL hold the FSM state encoding, the constant TIMEOUT_DATA=32'hDEADBEEF, and the register-address width 5.
REQ-027 The watchdog SHALL be sub-module mem_watchdog (enable, clear, expired), instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-028 ALU op (MemRead=MemWrite=0, aluresult=32'h0000_0042, RegWrite=1) -> stall=0 and aluresultout=32'h42 with RegWriteOut=1 in the same cycle.
REQ-029 Load at aluresult=32'h0000_0103, mem_ack in the first ACCESS cycle, mem_rdata=32'hCAFEF00D -> mem_addr=32'h100, exactly 2 stall cycles, memdataout=32'hCAFEF00D in DONE.
REQ-030 Store with writedata=32'h1234_5678 and mem_ack delayed 5 cycles -> mem_we=1 held stable, 6 stall cycles, memdataout unchanged, RegWriteOut=0 while stalled.
REQ-031 rst_n pulsed low during the third ACCESS cycle -> mem_req=0 immediately, state IDLE, memdataout=0, and a later mem_ack is ignored.
REQ-032 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, a load with no ack -> DONE after 4 ACCESS cycles, memdataout=32'hDEADBEEF, mem_error=1 until reset.
